// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and helpers for the CPU load/store unit.
package mips_cpu_lsu_pkg;

    localparam logic [31:0]  LSU_DATA_BASE  = 32'h0000_1000;
    localparam int unsigned  LSU_DATA_WORDS = 32;
    localparam int unsigned  XLEN           = 32;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Request fields kept for the duration of one transaction.
    typedef struct packed {
        lsu_op_t         op;
        logic [1:0]      byte_off;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    function automatic logic is_load(input lsu_op_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_store(input lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Big-endian lane extract/extend for loads, lane merge for sub-word stores,
// and natural-alignment check.
module mips_cpu_lsu_align
    import mips_cpu_lsu_pkg::*;
(
    input  lsu_op_t          op,
    input  logic [1:0]       byte_off,
    input  logic [XLEN-1:0]  rdata,
    input  logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_data_c,
    output logic [XLEN-1:0]  store_data_c,
    output logic             misaligned_c
);

    logic [4:0]      byte_sh;
    logic [4:0]      half_sh;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [XLEN-1:0] byte_mask;
    logic [XLEN-1:0] half_mask;

    // Offset 0 is the most significant lane, so shift by (3 - offset) bytes.
    assign byte_sh   = {~byte_off, 3'b000};
    assign half_sh   = {~byte_off[1], 4'b0000};
    assign lane_b    = 8'(rdata >> byte_sh);
    assign lane_h    = 16'(rdata >> half_sh);
    assign byte_mask = 32'h0000_00FF << byte_sh;
    assign half_mask = 32'h0000_FFFF << half_sh;

    always_comb begin
        load_data_c = rdata;
        case (op)
            LB:      load_data_c = {{24{lane_b[7]}}, lane_b};
            LBU:     load_data_c = {24'h0, lane_b};
            LH:      load_data_c = {{16{lane_h[15]}}, lane_h};
            LHU:     load_data_c = {16'h0, lane_h};
            default: load_data_c = rdata;
        endcase
    end

    always_comb begin
        store_data_c = wdata;
        case (op)
            SB:      store_data_c = (rdata & ~byte_mask) | (32'(wdata[7:0]) << byte_sh);
            SH:      store_data_c = (rdata & ~half_mask) | (32'(wdata[15:0]) << half_sh);
            default: store_data_c = wdata;
        endcase
    end

    always_comb begin
        misaligned_c = 1'b0;
        case (op)
            LH, LHU, SH: misaligned_c = byte_off[0];
            LW, SW:      misaligned_c = |byte_off;
            default:     misaligned_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// Load/store initiator: one request at a time, RMW for sub-word stores on a
// word-wide memory port without byte enables.
module mips_cpu_lsu
    import mips_cpu_lsu_pkg::*;
#(
    parameter logic [31:0] DATA_BASE  = LSU_DATA_BASE,
    parameter int unsigned DATA_WORDS = LSU_DATA_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  lsu_op_t          req_op,
    input  logic [XLEN-1:0]  req_addr,
    input  logic [XLEN-1:0]  req_wdata,
    output logic             resp_valid,
    output logic [XLEN-1:0]  resp_rdata,
    output logic             resp_err,
    output logic [XLEN-1:0]  data_address,
    output logic             data_read,
    output logic             data_write,
    output logic [XLEN-1:0]  data_writedata,
    input  logic [XLEN-1:0]  data_readdata
);

    localparam logic [32:0] MAP_LO = 33'(DATA_BASE);
    localparam logic [32:0] MAP_HI = 33'(DATA_BASE) + (33'(DATA_WORDS) << 2);

    lsu_state_t      state;
    lsu_req_t        req_q;
    lsu_op_t         op_sel;
    logic [1:0]      off_sel;
    logic [XLEN-1:0] load_data_c;
    logic [XLEN-1:0] store_data_c;
    logic            misaligned_c;
    logic            in_range_c;
    logic            req_err_c;

    // Handshake and memory strobes decode from state only, so an async reset
    // mid-transaction removes data_write before the next clock edge.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign data_read  = (state == RD);
    assign data_write = (state == WR);

    // In IDLE the aligner checks the incoming request; otherwise it serves
    // the latched one.
    always_comb begin
        op_sel  = req_q.op;
        off_sel = req_q.byte_off;
        if (state == IDLE) begin
            op_sel  = req_op;
            off_sel = req_addr[1:0];
        end
    end

    assign in_range_c = (33'(req_addr) >= MAP_LO) && (33'(req_addr) < MAP_HI);
    assign req_err_c  = misaligned_c || !in_range_c;

    mips_cpu_lsu_align u_align (
        .op           (op_sel),
        .byte_off     (off_sel),
        .rdata        (data_readdata),
        .wdata        (req_q.wdata),
        .load_data_c  (load_data_c),
        .store_data_c (store_data_c),
        .misaligned_c (misaligned_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_q          <= '0;
            data_address   <= '0;
            data_writedata <= '0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_q.op       <= req_op;
                        req_q.byte_off <= req_addr[1:0];
                        req_q.wdata    <= req_wdata;
                        data_address   <= {req_addr[31:2], 2'b00};
                        if (req_err_c) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_op == SW) begin
                            data_writedata <= req_wdata;
                            state          <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (is_load(req_q.op)) begin
                        resp_rdata <= load_data_c;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else begin
                        data_writedata <= store_data_c;
                        state          <= WR;
                    end
                end
                WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Scoreboard bench for mips_cpu_lsu with a word-wide data memory model.
module tb_mips_cpu_lsu;
    import mips_cpu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        preload = 1'b1;
    logic        req_valid;
    logic        req_ready;
    lsu_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          rd_cyc;
        int          wr_cyc;
        int          resp_cyc;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_resp = 0;
    int          cyc = 0;
    logic [31:0] mem [32];
    logic [4:0]  widx;
    logic        m_rd, m_wr, m_rdy;
    exp_t        m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_cpu_lsu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    // Memory: combinational read, write on posedge.
    assign widx          = 5'((data_address - 32'h0000_1000) >> 2);
    assign data_readdata = mem[widx];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i) * 32'h0101_0101;
            mem[0]  <= 32'h0000_0000;
            mem[1]  <= 32'h8899_AABB;
            mem[31] <= 32'h0123_4567;
        end else if (data_write) begin
            mem[widx] <= data_writedata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_wdata, input logic hold, input string name);
        int   waited = 0;
        exp_t e;
        @(negedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waited < 50) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept: req_ready stuck low for %0d cycles", name, waited);
            req_valid = 1'b0;
            return;
        end
        e.name  = name;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cyc;
        e.waddr = {addr[31:2], 2'b00};
        e.wdata = exp_wdata;
        if (exp_err) begin
            e.rd_cyc = -1; e.wr_cyc = -1; e.resp_cyc = cyc + 1;
        end else if (is_load(op)) begin
            e.rd_cyc = cyc + 1; e.wr_cyc = -1; e.resp_cyc = cyc + 2;
        end else if (op == SW) begin
            e.rd_cyc = -1; e.wr_cyc = cyc + 1; e.resp_cyc = cyc + 2;
        end else begin
            e.rd_cyc = cyc + 1; e.wr_cyc = cyc + 2; e.resp_cyc = cyc + 3;
        end
        sb.push_back(e);
        n_acc++;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses outstanding", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: per-cycle strobe/handshake checks and response scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !preload) begin
                m_rd  = 1'b0;
                m_wr  = 1'b0;
                m_rdy = 1'b1;
                if (sb.size() != 0) begin
                    m_rdy = (cyc <= sb[0].acc);
                    m_rd  = (cyc == sb[0].rd_cyc);
                    m_wr  = (cyc == sb[0].wr_cyc);
                end
                chk("req_ready", 32'(req_ready), 32'(m_rdy));
                chk("data_read", 32'(data_read), 32'(m_rd));
                chk("data_write", 32'(data_write), 32'(m_wr));
                if ((data_read || data_write) && sb.size() != 0)
                    chk({sb[0].name, " data_address"}, data_address, sb[0].waddr);
                if (data_write && sb.size() != 0)
                    chk({sb[0].name, " data_writedata"}, data_writedata, sb[0].wdata);
                if (resp_valid) begin
                    n_resp++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious resp_valid: rdata %h err %0b", resp_rdata, resp_err);
                    end else begin
                        m_e = sb.pop_front();
                        chk({m_e.name, " rdata"}, resp_rdata, m_e.rdata);
                        chk({m_e.name, " err"}, 32'(resp_err), 32'(m_e.err));
                        chk({m_e.name, " resp cycle"}, 32'(cyc), 32'(m_e.resp_cyc));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0;
        req_op    = LB;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_err", 32'(resp_err), 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst data_read", 32'(data_read), 32'd0);
        chk("rst data_write", 32'(data_write), 32'd0);
        chk("rst data_address", data_address, 32'd0);
        chk("rst data_writedata", data_writedata, 32'd0);
        @(negedge clk);
        preload = 1'b0;
        rst_n   = 1'b1;

        // Loads from 0x1004 = 0x8899AABB
        issue(LB,  32'h1005, 0, 32'hFFFF_FF99, 1'b0, 0, 1'b0, "LB 1005");  drain();
        issue(LBU, 32'h1005, 0, 32'h0000_0099, 1'b0, 0, 1'b0, "LBU 1005"); drain();
        issue(LH,  32'h1006, 0, 32'hFFFF_AABB, 1'b0, 0, 1'b0, "LH 1006");  drain();
        issue(LHU, 32'h1006, 0, 32'h0000_AABB, 1'b0, 0, 1'b0, "LHU 1006"); drain();
        issue(LW,  32'h1004, 0, 32'h8899_AABB, 1'b0, 0, 1'b0, "LW 1004");  drain();
        issue(SB,  32'h1007, 32'h1234_5677, 0, 1'b0, 32'h8899_AA77, 1'b0, "SB 1007"); drain();
        issue(LW,  32'h1004, 0, 32'h8899_AA77, 1'b0, 0, 1'b0, "LW 1004 after SB"); drain();

        // Errors: misaligned and out of range
        issue(SW,  32'h1002, 32'hDEAD_0000, 0, 1'b1, 0, 1'b0, "SW 1002 err"); drain();
        issue(LW,  32'h0FFC, 0, 0, 1'b1, 0, 1'b0, "LW 0FFC err"); drain();
        issue(LB,  32'h0FFF, 0, 0, 1'b1, 0, 1'b0, "LB 0FFF err"); drain();
        issue(LB,  32'h1080, 0, 0, 1'b1, 0, 1'b0, "LB 1080 err"); drain();
        issue(LH,  32'h1005, 0, 0, 1'b1, 0, 1'b0, "LH 1005 err"); drain();

        // Top/bottom of the mapped range
        issue(LW,  32'h107C, 0, 32'h0123_4567, 1'b0, 0, 1'b0, "LW 107C"); drain();
        issue(LB,  32'h107F, 0, 32'h0000_0067, 1'b0, 0, 1'b0, "LB 107F"); drain();
        issue(LB,  32'h107D, 0, 32'h0000_0023, 1'b0, 0, 1'b0, "LB 107D"); drain();
        issue(LH,  32'h107C, 0, 32'h0000_0123, 1'b0, 0, 1'b0, "LH 107C"); drain();
        issue(LHU, 32'h107E, 0, 32'h0000_4567, 1'b0, 0, 1'b0, "LHU 107E"); drain();
        issue(SB,  32'h1000, 32'h0000_005A, 0, 1'b0, 32'h5A00_0000, 1'b0, "SB 1000"); drain();
        issue(LW,  32'h1000, 0, 32'h5A00_0000, 1'b0, 0, 1'b0, "LW 1000"); drain();

        // Restore 0x1004, then reset during the WR cycle of an SH
        issue(SW,  32'h1004, 32'h8899_AABB, 0, 1'b0, 32'h8899_AABB, 1'b0, "SW 1004"); drain();
        issue(SH,  32'h1004, 32'h0000_CAFE, 0, 1'b0, 32'hCAFE_AABB, 1'b0, "SH 1004 rst");
        @(posedge clk); #1;
        chk("SH rst in WR data_write", 32'(data_write), 32'd1);
        chk("SH rst in WR data_writedata", data_writedata, 32'hCAFE_AABB);
        rst_n = 1'b0;
        #1;
        chk("SH rst data_write drop", 32'(data_write), 32'd0);
        chk("SH rst req_ready", 32'(req_ready), 32'd1);
        chk("SH rst resp_valid", 32'(resp_valid), 32'd0);
        sb.delete();
        n_acc--;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("SH rst mem word", mem[1], 32'h8899_AABB);
        issue(LW,  32'h1004, 0, 32'h8899_AABB, 1'b0, 0, 1'b0, "LW 1004 after rst"); drain();
        issue(SW,  32'h1008, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, "SW 1008"); drain();

        // req_valid held high across back-to-back mixed requests
        issue(LW,  32'h1008, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, "hold LW 1008");
        issue(SB,  32'h1008, 32'hAAAA_AA11, 0, 1'b0, 32'h11AD_BEEF, 1'b1, "hold SB 1008");
        issue(LBU, 32'h1008, 0, 32'h0000_0011, 1'b0, 0, 1'b1, "hold LBU 1008");
        issue(SH,  32'h100A, 32'hFFFF_5555, 0, 1'b0, 32'h11AD_5555, 1'b1, "hold SH 100A");
        issue(LH,  32'h100A, 0, 32'h0000_5555, 1'b0, 0, 1'b1, "hold LH 100A");
        issue(LB,  32'h1009, 0, 32'hFFFF_FFAD, 1'b0, 0, 1'b1, "hold LB 1009");
        issue(LH,  32'h1009, 0, 0, 1'b1, 0, 1'b1, "hold LH 1009 err");
        issue(LW,  32'h1008, 0, 32'h11AD_5555, 1'b0, 0, 1'b1, "hold LW 1008");
        req_valid = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        #1;
        chk("response count", 32'(n_resp), 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
